kernel_window_sequencer: RTL and testbench

- Controls a 3-bank row-buffer memory that holds a binary (1 bit/pixel) 320x240 frame as a ring of three rows.
- Accepts the thresholded pixel stream under a valid/ready handshake and writes row r into bank r mod 3.
- After each row completes, stalls the input and replays the buffered rows to emit one 3x3 neighbourhood per pixel, in raster order, to the downstream morphology/filter stage.
- Out-of-frame neighbours are filled by edge replication.

---
 rtl/kernel_window_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_kernel_window_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_window_sequencer.sv
// Row-buffer controller for a 3-bank binary line memory.
// Writes incoming rows, then replays them as 3x3 windows.
module kernel_window_sequencer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int XW     = 9,
    parameter int YW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          pixel_in,
    input  logic          pixel_valid,
    output logic          pixel_ready,
    output logic [2:0]    wr_en,
    output logic [XW-1:0] wr_addr,
    output logic          wr_data,
    output logic [XW-1:0] rd_addr,
    input  logic [2:0]    rd_data,
    output logic [8:0]    kernel_out,
    output logic          kernel_valid,
    output logic [XW-1:0] kernel_x,
    output logic [YW-1:0] kernel_y,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_EMIT
    } state_t;

    localparam logic [XW-1:0] XLAST  = XW'(WIDTH - 1);
    localparam logic [XW-1:0] XWID   = XW'(WIDTH);
    localparam logic [XW-1:0] ERIGHT = XW'(WIDTH + 1);
    localparam logic [XW-1:0] ELAST  = XW'(WIDTH + 2);
    localparam logic [YW-1:0] YLAST  = YW'(HEIGHT - 1);
    localparam logic [YW-1:0] YPEN   = YW'(HEIGHT - 2);
    localparam logic [YW-1:0] YFULL  = YW'(HEIGHT);

    function automatic logic [1:0] inc3(input logic [1:0] b);
        return (b == 2'd2) ? 2'd0 : b + 2'd1;
    endfunction

    state_t          state_q, state_d;
    logic [XW-1:0]   wx_q, wx_d;
    logic [YW-1:0]   wy_q, wy_d;
    logic [1:0]      wb_q, wb_d;
    logic [YW-1:0]   ey_q, ey_d;
    logic [1:0]      cb_q, cb_d;
    logic [XW-1:0]   e_q, e_d;
    logic [2:0]      col1_q, col1_d;
    logic [2:0]      col2_q, col2_d;
    logic [8:0]      kout_q, kout_d;
    logic            kv_q, kv_d;
    logic [XW-1:0]   kx_q, kx_d;
    logic [YW-1:0]   ky_q, ky_d;
    logic            fd_q, fd_d;

    logic            accept;
    logic            last_col;
    logic            emit_last;
    logic            reemit;
    logic [1:0]      abank;
    logic [1:0]      bbank;
    logic [2:0]      col_w;
    logic [2:0]      lft;
    logic [2:0]      rgt;

    assign accept    = pixel_valid & pixel_ready;
    assign last_col  = (wx_q == XLAST);
    assign emit_last = (e_q == ELAST);
    assign reemit    = (ey_q == YPEN) && (wy_q == YFULL);

    // Top and bottom rows replicate the centre bank vertically.
    assign abank = (ey_q == '0) ? cb_q : inc3(inc3(cb_q));
    assign bbank = (ey_q == YLAST) ? cb_q : inc3(cb_q);
    assign col_w = {rd_data[abank], rd_data[cb_q], rd_data[bbank]};

    assign lft = (e_q == XW'(2)) ? col2_q : col1_q;
    assign rgt = (e_q == ERIGHT) ? col2_q : col_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = S_WRITE;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_WRITE: begin
                    if (accept && last_col && wy_q != '0) begin
                        state_d = S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (emit_last) begin
                        if (reemit) begin
                            state_d = S_EMIT;
                        end else if (ey_q == YLAST) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WRITE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pixel_ready = (state_q == S_WRITE);
        busy        = (state_q != S_IDLE);
        wr_en       = accept ? (3'b001 << wb_q) : 3'b000;
        wr_addr     = wx_q;
        wr_data     = pixel_in;
        rd_addr     = '0;
        if (state_q == S_EMIT && e_q < XWID) begin
            rd_addr = e_q;
        end
    end

    always_comb begin
        wx_d   = wx_q;
        wy_d   = wy_q;
        wb_d   = wb_q;
        ey_d   = ey_q;
        cb_d   = cb_q;
        e_d    = e_q;
        col1_d = col1_q;
        col2_d = col2_q;
        kout_d = kout_q;
        kx_d   = kx_q;
        ky_d   = ky_q;
        kv_d   = 1'b0;
        fd_d   = 1'b0;
        if (frame_start) begin
            wx_d = '0;
            wy_d = '0;
            wb_d = '0;
            e_d  = '0;
        end else if (state_q == S_WRITE && accept) begin
            if (last_col) begin
                wx_d = '0;
                wy_d = wy_q + YW'(1);
                wb_d = inc3(wb_q);
                if (wy_q != '0) begin
                    ey_d = wy_q - YW'(1);
                    cb_d = inc3(inc3(wb_q));
                    e_d  = '0;
                end
            end else begin
                wx_d = wx_q + XW'(1);
            end
        end else if (state_q == S_EMIT) begin
            e_d = e_q + XW'(1);
            if (e_q >= XW'(1) && e_q <= XWID) begin
                col2_d = col_w;
                col1_d = col2_q;
            end
            if (e_q >= XW'(2) && e_q <= ERIGHT) begin
                kv_d   = 1'b1;
                kx_d   = e_q - XW'(2);
                ky_d   = ey_q;
                kout_d = {lft[2], col2_q[2], rgt[2],
                          lft[1], col2_q[1], rgt[1],
                          lft[0], col2_q[0], rgt[0]};
            end
            if (emit_last) begin
                e_d = '0;
                if (reemit) begin
                    ey_d = ey_q + YW'(1);
                    cb_d = inc3(cb_q);
                end else if (ey_q == YLAST) begin
                    fd_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wx_q   <= '0;
            wy_q   <= '0;
            wb_q   <= '0;
            ey_q   <= '0;
            cb_q   <= '0;
            e_q    <= '0;
            col1_q <= '0;
            col2_q <= '0;
            kout_q <= '0;
            kv_q   <= 1'b0;
            kx_q   <= '0;
            ky_q   <= '0;
            fd_q   <= 1'b0;
        end else begin
            wx_q   <= wx_d;
            wy_q   <= wy_d;
            wb_q   <= wb_d;
            ey_q   <= ey_d;
            cb_q   <= cb_d;
            e_q    <= e_d;
            col1_q <= col1_d;
            col2_q <= col2_d;
            kout_q <= kout_d;
            kv_q   <= kv_d;
            kx_q   <= kx_d;
            ky_q   <= ky_d;
            fd_q   <= fd_d;
        end
    end

    assign kernel_out   = kout_q;
    assign kernel_valid = kv_q;
    assign kernel_x     = kx_q;
    assign kernel_y     = ky_q;
    assign frame_done   = fd_q;

endmodule

// File: tb/tb_kernel_window_sequencer.sv
// Bench for kernel_window_sequencer on a reduced frame.
// Kernels are predicted from the pixel image with clamped coordinates.
module tb_kernel_window_sequencer;

    localparam int W  = 12;
    localparam int H  = 6;
    localparam int XW = 9;
    localparam int YW = 8;

    typedef struct packed {
        logic [8:0]  k;
        logic [15:0] x;
        logic [15:0] y;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          pixel_in;
    logic          pixel_valid;
    logic          pixel_ready;
    logic [2:0]    wr_en;
    logic [XW-1:0] wr_addr;
    logic          wr_data;
    logic [XW-1:0] rd_addr;
    logic [2:0]    rd_data;
    logic [8:0]    kernel_out;
    logic          kernel_valid;
    logic [XW-1:0] kernel_x;
    logic [YW-1:0] kernel_y;
    logic          busy;
    logic          frame_done;

    kernel_window_sequencer #(
        .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_start(frame_start),
        .pixel_in(pixel_in),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .kernel_out(kernel_out),
        .kernel_valid(kernel_valid),
        .kernel_x(kernel_x),
        .kernel_y(kernel_y),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   fd_cnt = 0;
    int   row1_cyc = 0;
    int   last_kv = 0;
    bit   first_kv = 0;
    bit   img [H][W];
    bit   mem [3][W];
    exp_t expq[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int b = 0; b < 3; b++) begin
            if (wr_en[b]) mem[b][wr_addr] <= wr_data;
        end
        rd_data <= {mem[2][rd_addr], mem[1][rd_addr], mem[0][rd_addr]};
    end

    always @(negedge clk) begin
        if (reset) begin
            if (kernel_valid) begin
                chk("rdy_in_emit", pixel_ready, 0);
                if (expq.size() == 0) begin
                    chk("extra_kv", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("kern", kernel_out, e.k);
                    chk("kx", kernel_x, e.x);
                    chk("ky", kernel_y, e.y);
                end
                if (first_kv) begin
                    chk("kv_lat", cyc - row1_cyc, 3);
                    first_kv = 0;
                end
                last_kv = cyc;
            end
            if (frame_done) begin
                fd_cnt++;
                chk("fd_lat", cyc - last_kv, 1);
            end
        end
    end

    function automatic bit px(input int x, input int y);
        int cx, cy;
        cx = (x < 0) ? 0 : (x > W - 1) ? W - 1 : x;
        cy = (y < 0) ? 0 : (y > H - 1) ? H - 1 : y;
        return img[cy][cx];
    endfunction

    task automatic build(input int pat, input int sx, input int sy);
        expq.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                unique case (pat)
                    0: img[y][x] = 1'($urandom_range(0, 1));
                    1: img[y][x] = 1'b1;
                    default: img[y][x] = (x == sx && y == sy);
                endcase
            end
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                exp_t e;
                e.k = {px(x-1,y-1), px(x,y-1), px(x+1,y-1),
                       px(x-1,y),   px(x,y),   px(x+1,y),
                       px(x-1,y+1), px(x,y+1), px(x+1,y+1)};
                e.x = 16'(x);
                e.y = 16'(y);
                expq.push_back(e);
            end
        end
    endtask

    task automatic rst_chk(input string p);
        chk({p, "_rdy"}, pixel_ready, 0);
        chk({p, "_kv"}, kernel_valid, 0);
        chk({p, "_fd"}, frame_done, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_wren"}, wr_en, 0);
        chk({p, "_kout"}, kernel_out, 0);
        chk({p, "_kx"}, kernel_x, 0);
        chk({p, "_ky"}, kernel_y, 0);
        chk({p, "_rda"}, rd_addr, 0);
    endtask

    // Starts aligned to a negedge and returns aligned to a negedge.
    task automatic run_frame(input int pat, input int sx, input int sy,
                             input bit thr, input bit nostart,
                             input int abort_row, input bit rst_mid);
        int idx, guard, fd0;
        bit tog;
        idx = 0;
        guard = 0;
        tog = 1;
        fd0 = fd_cnt;
        build(pat, sx, sy);
        first_kv = 1;
        if (!nostart) begin
            frame_start = 1;
            pixel_valid = 1;
            #1 chk("rdy_at_start", pixel_ready, 0);
            @(negedge clk);
            frame_start = 0;
        end
        while (idx < W * H && guard < 20 * W * H) begin
            if (abort_row >= 0 && kernel_valid &&
                int'(kernel_y) == abort_row) begin
                frame_start = 1;
                pixel_valid = 0;
                @(negedge clk);
                frame_start = 0;
                #1;
                chk("abort_kv", kernel_valid, 0);
                chk("abort_busy", busy, 1);
                chk("abort_fd", fd_cnt - fd0, 0);
                expq.delete();
                @(negedge clk);
                return;
            end
            if (rst_mid && kernel_valid) begin
                reset = 0;
                #1 rst_chk("mid");
                @(negedge clk);
                reset = 1;
                pixel_valid = 1;
                repeat (3) begin
                    #1;
                    chk("post_busy", busy, 0);
                    chk("post_rdy", pixel_ready, 0);
                    chk("post_wren", wr_en, 0);
                    @(negedge clk);
                end
                pixel_valid = 0;
                expq.delete();
                return;
            end
            pixel_valid = thr ? tog : 1'b1;
            tog = ~tog;
            pixel_in = img[idx / W][idx % W];
            #4;
            if (pixel_valid && pixel_ready) begin
                if (idx == 0 && nostart) begin
                    chk("restart_wr", {wr_en, 7'(0), wr_addr}, 19'h10000);
                end
                if (idx == 2 * W - 1) row1_cyc = cyc + 1;
                idx++;
            end
            guard++;
            @(negedge clk);
        end
        pixel_valid = 0;
        if (idx < W * H) chk("feed_timeout", idx, W * H);
        guard = 0;
        while (guard < 8 * W) begin
            @(negedge clk);
            #1;
            if (fd_cnt != fd0) break;
            guard++;
        end
        chk("fd_cnt", fd_cnt - fd0, 1);
        chk("q_empty", expq.size(), 0);
        chk("end_busy", busy, 0);
        chk("end_rdy", pixel_ready, 0);
        @(negedge clk);
    endtask

    initial begin
        reset = 0;
        frame_start = 0;
        pixel_in = 0;
        pixel_valid = 0;
        #12;
        rst_chk("rst");
        @(negedge clk);
        reset = 1;
        pixel_valid = 1;
        repeat (4) begin
            #1;
            chk("idle_rdy", pixel_ready, 0);
            chk("idle_busy", busy, 0);
            @(negedge clk);
        end
        pixel_valid = 0;
        run_frame(1, 0, 0, 0, 0, -1, 0);
        run_frame(2, 5, 0, 0, 0, -1, 0);
        run_frame(2, W - 1, H - 1, 0, 0, -1, 0);
        run_frame(0, 0, 0, 1, 0, -1, 0);
        run_frame(0, 0, 0, 0, 0, -1, 1);
        run_frame(0, 0, 0, 0, 0, 2, 0);
        run_frame(0, 0, 0, 0, 1, -1, 0);
        run_frame(0, 0, 0, 1, 0, -1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
